// File: rtl/sa_drain_pkg.sv
// ----------------------------------------------------------------------------
// sa_drain_pkg
// Shared definitions for the DOWN SRAM drain reader.
//   drain_state_e : drain FSM states (IDLE, FETCH, CAPTURE, SEND, DONE)
//   word_count()  : number of words in an inclusive address range whose end
//                   may wrap through the top of the bank back to address 0
// ----------------------------------------------------------------------------
package sa_drain_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } drain_state_e;

    // ((end - start) mod 2^aw) + 1; start == end gives one word.
    function automatic int unsigned word_count(input int unsigned start_addr,
                                               input int unsigned end_addr,
                                               input int unsigned aw);
        return ((end_addr - start_addr) & ((32'd1 << aw) - 32'd1)) + 32'd1;
    endfunction

endpackage

// File: rtl/down_sram_drain_reader_if.sv
// ----------------------------------------------------------------------------
// down_sram_drain_reader_if
// Single-element valid/ready stream carrying accumulator elements.
//   valid : element valid (source -> sink)
//   data  : element, OUT_DATA_WIDTH bits (source -> sink)
//   last  : final element of the drained range (source -> sink)
//   ready : sink accepts (sink -> source)
// Modports: master = stream source, slave = stream sink.
// ----------------------------------------------------------------------------
interface down_sram_drain_reader_if #(
    parameter int OUT_DATA_WIDTH = 32
);
    logic                      valid;
    logic [OUT_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/drain_col_serializer.sv
// ----------------------------------------------------------------------------
// drain_col_serializer
// Holds one NUM_COL-wide word and presents its columns, column 0 first, on a
// valid/ready stream.
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : load i_load_word/i_load_final and restart at column 0
//   i_load_word   : NUM_COL*OUT_DATA_WIDTH word to serialize
//   i_load_final  : the loaded word is the last of the range
//   i_ready       : downstream accept
//   o_valid/o_data/o_last : stream outputs
//   o_last_hs     : handshake of column NUM_COL-1 this cycle
// ----------------------------------------------------------------------------
module drain_col_serializer #(
    parameter int NUM_COL        = 4,
    parameter int OUT_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_load,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_load_word,
    input  logic                              i_load_final,
    input  logic                              i_ready,
    output logic                              o_valid,
    output logic [OUT_DATA_WIDTH-1:0]         o_data,
    output logic                              o_last,
    output logic                              o_last_hs
);
    localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

    logic [NUM_COL*OUT_DATA_WIDTH-1:0] word_q, word_d;
    logic [COL_W-1:0]                  col_q, col_d;
    logic                              valid_q, valid_d;
    logic                              final_q, final_d;
    logic                              at_last;
    logic                              hs;

    assign at_last   = (col_q == LAST_COL);
    assign hs        = valid_q & i_ready;
    assign o_last_hs = hs & at_last;
    assign o_valid   = valid_q;
    assign o_last    = valid_q & final_q & at_last;
    assign o_data    = valid_q ? word_q[int'(col_q)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]
                               : '0;

    always_comb begin
        word_d  = word_q;
        col_d   = col_q;
        valid_d = valid_q;
        final_d = final_q;
        if (hs) begin
            if (at_last) begin
                valid_d = 1'b0;
                col_d   = '0;
            end else begin
                col_d   = col_q + COL_W'(1);
            end
        end
        // A load on the last-column handshake chains the next word with no gap.
        if (i_load) begin
            word_d  = i_load_word;
            col_d   = '0;
            valid_d = 1'b1;
            final_d = i_load_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            final_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            final_q <= final_d;
        end
    end
endmodule

// File: rtl/down_sram_drain_reader.sv
// ----------------------------------------------------------------------------
// down_sram_drain_reader
// Reads an inclusive (possibly wrapping) range of DOWN SRAM words on a start
// pulse and streams their columns, column 0 first, on a valid/ready stream.
//   clk, rst            : clock, synchronous active-high reset
//   i_start             : start request, taken only in IDLE
//   i_rd_start_addr     : first word address (latched on accepted start)
//   i_rd_end_addr       : last word address, inclusive (latched likewise)
//   o_busy              : drain in progress (through the DONE cycle)
//   o_done              : one-cycle pulse after the final handshake
//   o_down_rd_en/addr   : SRAM read port, data returns one cycle later
//   i_down_rd_data      : SRAM read data
//   m_strm              : element stream (master modport)
// Build option: define DRAIN_PREFETCH_EN to fetch word k+1 while word k is
// being sent, removing the inter-word bubbles.
// ----------------------------------------------------------------------------
module down_sram_drain_reader
    import sa_drain_pkg::*;
#(
    parameter int NUM_COL              = 4,
    parameter int OUT_DATA_WIDTH       = 32,
    parameter int LOG2_SRAM_BANK_DEPTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_rd_end_addr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_down_rd_data,
    down_sram_drain_reader_if.master          m_strm
);
    localparam int AW     = LOG2_SRAM_BANK_DEPTH;
    localparam int CNT_W  = LOG2_SRAM_BANK_DEPTH + 1;
    localparam int WORD_W = NUM_COL * OUT_DATA_WIDTH;

    drain_state_e      state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    // Words of the range whose read has not been issued yet.
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              ld;
    logic              ld_final;
    logic [WORD_W-1:0] ld_data;
    logic              last_hs;
    logic              rd_en;

`ifdef DRAIN_PREFETCH_EN
    logic              pf_issued_q, pf_issued_d;  // next word's read already issued
    logic              rd_pend_q, rd_pend_d;      // prefetch data on the bus this cycle
    logic              pf_valid_q, pf_valid_d;    // prefetch register holds a word
    logic [WORD_W-1:0] pf_word_q, pf_word_d;
`endif

    assign o_down_rd_en   = rd_en;
    assign o_down_rd_addr = rd_en ? addr_q : '0;
    assign o_busy         = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        rd_en    = 1'b0;
        o_done   = 1'b0;
        ld       = 1'b0;
        ld_final = 1'b0;
        ld_data  = i_down_rd_data;
`ifdef DRAIN_PREFETCH_EN
        pf_issued_d = pf_issued_q;
        rd_pend_d   = 1'b0;
        pf_valid_d  = pf_valid_q;
        pf_word_d   = pf_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FETCH;
                    addr_d  = i_rd_start_addr;
                    rem_d   = CNT_W'(word_count(32'(i_rd_start_addr),
                                                32'(i_rd_end_addr), 32'(AW)));
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                addr_d  = addr_q + AW'(1);
                rem_d   = rem_q - CNT_W'(1);
                state_d = CAPTURE;
            end
            CAPTURE: begin
                ld       = 1'b1;
                ld_final = (rem_q == '0);
                state_d  = SEND;
`ifdef DRAIN_PREFETCH_EN
                pf_issued_d = 1'b0;
`endif
            end
            SEND: begin
`ifdef DRAIN_PREFETCH_EN
                if (!pf_issued_q && (rem_q != '0)) begin
                    rd_en       = 1'b1;
                    addr_d      = addr_q + AW'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    pf_issued_d = 1'b1;
                    rd_pend_d   = 1'b1;
                end
                // Park returning prefetch data unless it is consumed directly.
                if (rd_pend_q && !last_hs) begin
                    pf_word_d  = i_down_rd_data;
                    pf_valid_d = 1'b1;
                end
                if (last_hs) begin
                    if (pf_valid_q) begin
                        ld          = 1'b1;
                        ld_data     = pf_word_q;
                        ld_final    = (rem_q == '0);
                        pf_valid_d  = 1'b0;
                        pf_issued_d = 1'b0;
                    end else if (rd_pend_q) begin
                        ld          = 1'b1;
                        ld_final    = (rem_q == '0);
                        pf_issued_d = 1'b0;
                    end else if (pf_issued_d) begin
                        // Read issued this very cycle (NUM_COL == 1): one bubble.
                        state_d = CAPTURE;
                    end else begin
                        state_d = DONE;
                    end
                end
`else
                if (last_hs) begin
                    state_d = (rem_q != '0) ? FETCH : DONE;
                end
`endif
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef DRAIN_PREFETCH_EN
            pf_issued_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            pf_valid_q  <= 1'b0;
            pf_word_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef DRAIN_PREFETCH_EN
            pf_issued_q <= pf_issued_d;
            rd_pend_q   <= rd_pend_d;
            pf_valid_q  <= pf_valid_d;
            pf_word_q   <= pf_word_d;
`endif
        end
    end

    drain_col_serializer #(
        .NUM_COL        (NUM_COL),
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .i_load       (ld),
        .i_load_word  (ld_data),
        .i_load_final (ld_final),
        .i_ready      (m_strm.ready),
        .o_valid      (m_strm.valid),
        .o_data       (m_strm.data),
        .o_last       (m_strm.last),
        .o_last_hs    (last_hs)
    );
endmodule

// File: tb/tb_down_sram_drain_reader.sv
// ----------------------------------------------------------------------------
// tb_down_sram_drain_reader
// Directed bench for down_sram_drain_reader with NUM_COL=4, 32-bit elements
// and a 32-deep bank. SRAM word at address a holds {4a+3,4a+2,4a+1,4a}.
// ----------------------------------------------------------------------------
module tb_down_sram_drain_reader;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef DRAIN_PREFETCH_EN
    localparam int SPAN4 = 19;  // accept cycle to o_done, 4 words, ready high
`else
    localparam int SPAN4 = 25;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic [AW-1:0]    i_rd_start_addr = '0;
    logic [AW-1:0]    i_rd_end_addr = '0;
    logic             o_busy, o_done, o_down_rd_en;
    logic [AW-1:0]    o_down_rd_addr;
    logic [NC*DW-1:0] rd_data = '0;

    down_sram_drain_reader_if #(.OUT_DATA_WIDTH(DW)) strm_if ();

    down_sram_drain_reader #(
        .NUM_COL(NC), .OUT_DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_rd_start_addr(i_rd_start_addr), .i_rd_end_addr(i_rd_end_addr),
        .o_busy(o_busy), .o_done(o_done),
        .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
        .i_down_rd_data(rd_data), .m_strm(strm_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NC*DW-1:0] mk_word(input int a);
        logic [NC*DW-1:0] w;
        for (int c = 0; c < NC; c++) w[c*DW +: DW] = DW'(4 * a + c);
        return w;
    endfunction

    // One-cycle-latency SRAM model.
    always @(posedge clk) if (o_down_rd_en) rd_data <= mk_word(int'(o_down_rd_addr));

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Ready driver: held high, or a repeating 1-0-0-1 pattern.
    bit       rmode = 1'b0;
    bit [3:0] rpat  = 4'b1001;
    int       rk    = 0;
    initial strm_if.ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rmode) begin
            strm_if.ready = rpat[rk];
            rk = (rk + 1) % 4;
        end else begin
            strm_if.ready = 1'b1;
        end
    end

    // Monitor: record handshakes, reads and done pulses; check stall stability.
    logic [DW-1:0] hs_data[$];
    bit            hs_last[$];
    int            hs_cyc[$];
    int            rd_addr[$];
    int            rd_cyc[$];
    int            done_cyc[$];
    int            stall_cnt = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    bit            prev_last;

    always @(negedge clk) begin
        if (prev_stall && !rst) begin
            chk("stall_valid", 64'(strm_if.valid), 64'd1);
            chk("stall_data", 64'(strm_if.data), 64'(prev_data));
            chk("stall_last", 64'(strm_if.last), 64'(prev_last));
        end
        prev_stall = strm_if.valid && !strm_if.ready && !rst;
        if (prev_stall) stall_cnt++;
        prev_data = strm_if.data;
        prev_last = strm_if.last;
        if (strm_if.valid && strm_if.ready) begin
            hs_data.push_back(strm_if.data);
            hs_last.push_back(strm_if.last);
            hs_cyc.push_back(cyc);
        end
        if (o_down_rd_en) begin
            rd_addr.push_back(int'(o_down_rd_addr));
            rd_cyc.push_back(cyc);
        end
        if (o_done) done_cyc.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        hs_data.delete(); hs_last.delete(); hs_cyc.delete();
        rd_addr.delete(); rd_cyc.delete(); done_cyc.delete();
        stall_cnt = 0;
    endtask

    // Pulses start for one cycle; t0 is the accepting cycle number.
    task automatic drive_start(input int s, input int e, output int t0);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_rd_start_addr = AW'(s);
        i_rd_end_addr = AW'(e);
        t0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_rd_start_addr = AW'(s + 9);
        i_rd_end_addr = AW'(e + 17);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < limit) begin
            tick();
            n++;
        end
        if (done_cyc.size() == 0) chk("done_timeout", 64'd0, 64'd1);
        tick();
        chk("busy_after_done", 64'(o_busy), 64'd0);
        repeat (3) tick();
    endtask

    // Compares the recorded drain of nwords words starting at first_addr.
    task automatic check_range(input string nm, input int first_addr, input int nwords,
                               input int t0, input bit timed);
        int n, a;
        n = nwords * NC;
        chk({nm, "_count"}, 64'(hs_data.size()), 64'(n));
        chk({nm, "_rd_count"}, 64'(rd_addr.size()), 64'(nwords));
        chk({nm, "_done_count"}, 64'(done_cyc.size()), 64'd1);
        for (int w = 0; w < nwords; w++) begin
            a = (first_addr + w) % 32;
            chk({nm, "_rd_addr"}, 64'(rd_addr[w]), 64'(a));
            for (int c = 0; c < NC; c++) begin
                chk({nm, "_data"}, 64'(hs_data[w*NC+c]), 64'(4 * a + c));
                chk({nm, "_last"}, 64'(hs_last[w*NC+c]), 64'((w*NC+c) == n - 1));
            end
        end
        chk({nm, "_done_after_last"}, 64'(done_cyc[0] - hs_cyc[n-1]), 64'd1);
        if (timed) begin
            chk({nm, "_first_rd"}, 64'(rd_cyc[0] - t0), 64'd1);
            chk({nm, "_first_valid"}, 64'(hs_cyc[0] - t0), 64'd3);
            for (int i = 1; i < n; i++) begin
`ifdef DRAIN_PREFETCH_EN
                chk({nm, "_gap"}, 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
`else
                chk({nm, "_gap"}, 64'(hs_cyc[i] - hs_cyc[i-1]), (i % NC == 0) ? 64'd3 : 64'd1);
`endif
            end
        end
    endtask

    initial begin
        int t0;
        int n;
        // Reset values
        repeat (3) @(posedge clk);
        tick();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_rd_en", 64'(o_down_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(o_down_rd_addr), 64'd0);
        chk("rst_valid", 64'(strm_if.valid), 64'd0);
        chk("rst_data", 64'(strm_if.data), 64'd0);
        chk("rst_last", 64'(strm_if.last), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Range 0..3, ready high: 16 elements 0..15
        clear_log();
        drive_start(0, 3, t0);
        wait_done(200);
        check_range("r0_3", 0, 4, t0, 1'b1);
        chk("r0_3_span", 64'(done_cyc[0] - t0), 64'(SPAN4));

        // Wrapping range 30..1: addresses 30,31,0,1
        clear_log();
        drive_start(30, 1, t0);
        wait_done(200);
        check_range("wrap", 30, 4, t0, 1'b1);

        // Single word 7..7 with ready 1-0-0-1: elements 28..31 with stalls
        clear_log();
        rk = 0;
        rmode = 1'b1;
        drive_start(7, 7, t0);
        wait_done(200);
        rmode = 1'b0;
        check_range("single", 7, 1, t0, 1'b0);
        chk("single_stalled", 64'(stall_cnt > 0), 64'd1);

        // Start pulsed mid-drain with another range: ignored
        clear_log();
        drive_start(0, 3, t0);
        repeat (6) tick();
        @(posedge clk); #1;
        i_start = 1'b1; i_rd_start_addr = 5'd10; i_rd_end_addr = 5'd12;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(200);
        check_range("midstart", 0, 4, t0, 1'b1);

        // Reset during SEND of the second word, then range 0..0
        clear_log();
        drive_start(0, 3, t0);
        n = 0;
        while (hs_data.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_mid_reached", 64'(hs_data.size()), 64'd5);
        rst = 1'b1;
        tick();
        chk("rstmid_busy", 64'(o_busy), 64'd0);
        chk("rstmid_done", 64'(o_done), 64'd0);
        chk("rstmid_rd_en", 64'(o_down_rd_en), 64'd0);
        chk("rstmid_rd_addr", 64'(o_down_rd_addr), 64'd0);
        chk("rstmid_valid", 64'(strm_if.valid), 64'd0);
        chk("rstmid_data", 64'(strm_if.data), 64'd0);
        chk("rstmid_last", 64'(strm_if.last), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        clear_log();
        drive_start(0, 0, t0);
        wait_done(200);
        check_range("after_rst", 0, 1, t0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
